pc_fetch_nway: RTL and testbench

PC_FETCH_NWAY -- requirements
Module: pc_fetch_nway

---
 rtl/pc_fetch_nway.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_nway.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_nway.sv
// Purpose: N-lane fetch PC generator with lowest-lane redirect arbitration and a stall-time pending redirect.
// Latency: pcf/lane_valid are registered; redir_ack/redir_lane are combinational in the cycle the redirect is applied.
// Backpressure: en=0 stalls; a redirect seen during a stall is latched and applied on the next en=1 cycle.
module pc_fetch_nway #(
  parameter int               WIDTH    = 32,
  parameter int               LANES    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               ALIGN    = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic [LANES-1:0]                        redir_valid,
  input  logic [2*LANES-1:0]                      redir_kind,
  input  logic [WIDTH*LANES-1:0]                  pc_target,
  input  logic [WIDTH*LANES-1:0]                  alu_result,
  output logic [WIDTH*LANES-1:0]                  pcf,
  output logic [LANES-1:0]                        lane_valid,
  output logic                                    redir_ack,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] redir_lane,
  output logic                                    redir_pending
);

  localparam int               LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [WIDTH-1:0] STEP  = WIDTH'(4 * LANES);
  localparam logic [WIDTH-1:0] AMASK = ~WIDTH'(4 * LANES - 1);
  localparam logic [LW-1:0]    LMASK = LW'(LANES - 1);

  // Base loaded from a target: group-aligned when ALIGN, otherwise the full target.
  function automatic logic [WIDTH-1:0] align_base(input logic [WIDTH-1:0] t);
    return (ALIGN != 0) ? (t & AMASK) : t;
  endfunction

  // First valid lane inside an aligned group; always 0 for unaligned groups.
  function automatic logic [LW-1:0] lane_off(input logic [WIDTH-1:0] t);
    return (ALIGN != 0) ? (LW'(t >> 2) & LMASK) : '0;
  endfunction

  localparam logic [WIDTH-1:0] RST_BASE = align_base(RESET_PC);
  localparam logic [LW-1:0]    RST_OFF  = lane_off(RESET_PC);

  typedef enum logic {RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [LW-1:0]    pend_lane_q, pend_lane_d;
  logic [LW-1:0]    offset_q, offset_d;
  logic             first_q, first_d;

  logic             req_any;
  logic [LW-1:0]    win_lane;
  logic [WIDTH-1:0] win_tgt;
  logic [WIDTH-1:0] ld_tgt;
  logic             ack_c;
  logic [LW-1:0]    lane_c;

  // Pick the lowest-index lane with a usable redirect kind (oldest instruction wins).
  always_comb begin
    req_any  = 1'b0;
    win_lane = '0;
    win_tgt  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (redir_valid[i] && (redir_kind[2*i +: 2] == 2'b01 || redir_kind[2*i +: 2] == 2'b10)) begin
        req_any  = 1'b1;
        win_lane = LW'(i);
        win_tgt  = (redir_kind[2*i +: 2] == 2'b01) ? pc_target[i*WIDTH +: WIDTH]
                                                  : (alu_result[i*WIDTH +: WIDTH] & ~WIDTH'(3));
      end
    end
  end

  // Target that gets loaded: the latched one when leaving PEND, else this cycle's winner.
  assign ld_tgt = (state_q == PEND) ? pend_tgt_q : win_tgt;

  // Next-state logic: redirect, advance, latch-on-stall, or hold.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    pend_tgt_d  = pend_tgt_q;
    pend_lane_d = pend_lane_q;
    offset_d    = offset_q;
    first_d     = first_q;
    ack_c       = 1'b0;
    lane_c      = '0;
    case (state_q)
      RUN: begin
        if (en) begin
          if (req_any) begin
            base_d   = align_base(ld_tgt);
            offset_d = lane_off(ld_tgt);
            first_d  = 1'b1;
            ack_c    = 1'b1;
            lane_c   = win_lane;
          end else begin
            base_d  = base_q + STEP;
            first_d = 1'b0;
          end
        end else if (req_any) begin
          pend_tgt_d  = win_tgt;
          pend_lane_d = win_lane;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (en) begin
          base_d      = align_base(ld_tgt);
          offset_d    = lane_off(ld_tgt);
          first_d     = 1'b1;
          ack_c       = 1'b1;
          lane_c      = pend_lane_q;
          pend_tgt_d  = '0;
          pend_lane_d = '0;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers; reset drops any pending redirect and restarts at RESET_PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      base_q      <= RST_BASE;
      pend_tgt_q  <= '0;
      pend_lane_q <= '0;
      offset_q    <= RST_OFF;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_lane_q <= pend_lane_d;
      offset_q    <= offset_d;
      first_q     <= first_d;
    end
  end

  // Per-lane PCs and validity; lanes below the entry offset are dead only in the first group.
  always_comb begin
    pcf        = '0;
    lane_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      pcf[i*WIDTH +: WIDTH] = base_q + WIDTH'(4 * i);
      lane_valid[i]         = (ALIGN == 0) || !first_q || (i >= int'(offset_q));
    end
  end

  // Status outputs; ack/lane are forced quiet while reset is asserted.
  always_comb begin
    redir_pending = (state_q == PEND);
    redir_ack     = ack_c & rst;
    redir_lane    = (ack_c & rst) ? lane_c : '0;
  end

endmodule

// File: tb/tb_pc_fetch_nway.sv
// Bench for pc_fetch_nway: two LANES=2 instances (unaligned, RESET_PC=0; aligned, RESET_PC=0x104).
// Driver pushes per-cycle expectations from a behavioural model; a negedge monitor pops and compares.
module tb_pc_fetch_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  redir_valid;
  logic [3:0]  redir_kind;
  logic [63:0] pc_target;
  logic [63:0] alu_result;

  logic [63:0] pcf_a, pcf_b;
  logic [1:0]  lv_a, lv_b;
  logic        ack_a, ack_b;
  logic [0:0]  lane_a, lane_b;
  logic        pend_a, pend_b;

  always #5 clk = ~clk;

  pc_fetch_nway #(.WIDTH(32), .LANES(2), .RESET_PC(32'h0), .ALIGN(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .redir_valid(redir_valid), .redir_kind(redir_kind),
    .pc_target(pc_target), .alu_result(alu_result), .pcf(pcf_a), .lane_valid(lv_a),
    .redir_ack(ack_a), .redir_lane(lane_a), .redir_pending(pend_a));

  pc_fetch_nway #(.WIDTH(32), .LANES(2), .RESET_PC(32'h104), .ALIGN(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .redir_valid(redir_valid), .redir_kind(redir_kind),
    .pc_target(pc_target), .alu_result(alu_result), .pcf(pcf_b), .lane_valid(lv_b),
    .redir_ack(ack_b), .redir_lane(lane_b), .redir_pending(pend_b));

  typedef struct packed {
    logic [63:0] pcf;
    logic [1:0]  lv;
    logic        ack;
    logic        lane;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc_no = 0;

  // Reference model state, one slot per instance (0 = unaligned, 1 = aligned)
  logic [31:0] m_base [2];
  logic [31:0] m_ptgt [2];
  bit          m_pend [2];
  bit          m_plane[2];
  bit          m_first[2];
  int          m_off  [2];

  function automatic logic [31:0] reset_pc(input int k);
    return (k == 1) ? 32'h104 : 32'h0;
  endfunction

  task automatic m_load(input int k, input logic [31:0] t);
    if (k == 1) begin
      m_base[k] = t - (t % 8);
      m_off[k]  = int'((t % 8) / 4);
    end else begin
      m_base[k] = t;
      m_off[k]  = 0;
    end
    m_first[k] = 1'b1;
  endtask

  task automatic m_reset(input int k);
    m_load(k, reset_pc(k));
    m_pend[k]  = 1'b0;
    m_ptgt[k]  = '0;
    m_plane[k] = 1'b0;
  endtask

  // Expected outputs for the current cycle, then advance the model across the coming edge
  task automatic model_cycle(input int k);
    exp_t        x;
    int          w;
    logic [31:0] tg;
    logic [1:0]  kd;
    if (!rst) m_reset(k);
    x.pcf  = {m_base[k] + 32'd4, m_base[k]};
    x.pend = m_pend[k];
    x.ack  = 1'b0;
    x.lane = 1'b0;
    for (int i = 0; i < 2; i++)
      x.lv[i] = (k == 1 && m_first[k]) ? (i >= m_off[k]) : 1'b1;
    w  = -1;
    tg = '0;
    for (int i = 0; i < 2; i++) begin
      kd = redir_kind[2*i +: 2];
      if (w < 0 && redir_valid[i] && (kd == 2'b01 || kd == 2'b10)) begin
        w  = i;
        tg = (kd == 2'b01) ? pc_target[32*i +: 32] : (alu_result[32*i +: 32] & 32'hFFFF_FFFC);
      end
    end
    if (rst) begin
      if (m_pend[k]) begin
        if (en) begin
          x.ack = 1'b1;
          x.lane = m_plane[k];
          m_load(k, m_ptgt[k]);
          m_pend[k] = 1'b0;
        end
      end else if (en) begin
        if (w >= 0) begin
          x.ack  = 1'b1;
          x.lane = w[0];
          m_load(k, tg);
        end else begin
          m_base[k]  = m_base[k] + 32'd8;
          m_first[k] = 1'b0;
        end
      end else if (w >= 0) begin
        m_pend[k]  = 1'b1;
        m_ptgt[k]  = tg;
        m_plane[k] = w[0];
      end
    end
    sb.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit e, input logic [1:0] v, input logic [3:0] kd,
                     input logic [31:0] pt0, input logic [31:0] pt1,
                     input logic [31:0] a0, input logic [31:0] a1);
    @(posedge clk);
    #1;
    rst         = r;
    en          = e;
    redir_valid = v;
    redir_kind  = kd;
    pc_target   = {pt1, pt0};
    alu_result  = {a1, a0};
    cyc_no++;
    model_cycle(0);
    model_cycle(1);
  endtask

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", nm, k, cyc_no, act, exp);
  endtask

  // Monitor: every driven cycle carries one expectation per instance
  always @(negedge clk) begin
    exp_t xa, xb;
    if (sb.size() >= 2) begin
      xa = sb.pop_front();
      xb = sb.pop_front();
      chk("pcf",           0, pcf_a,  xa.pcf);
      chk("lane_valid",    0, lv_a,   xa.lv);
      chk("redir_ack",     0, ack_a,  xa.ack);
      chk("redir_lane",    0, lane_a, xa.lane);
      chk("redir_pending", 0, pend_a, xa.pend);
      chk("pcf",           1, pcf_b,  xb.pcf);
      chk("lane_valid",    1, lv_b,   xb.lv);
      chk("redir_ack",     1, ack_b,  xb.ack);
      chk("redir_lane",    1, lane_b, xb.lane);
      chk("redir_pending", 1, pend_b, xb.pend);
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; redir_valid = '0; redir_kind = '0; pc_target = '0; alu_result = '0;
    for (int k = 0; k < 2; k++) m_reset(k);

    // Reset values
    cyc(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0);
    cyc(0, 1, 2'b11, 4'b0101, 32'h10, 32'h20, 0, 0);
    // Straight-line advance
    repeat (3) cyc(1, 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    // Two lanes request: lane0 (jalr, low bits cleared) beats lane1
    cyc(1, 1, 2'b11, 4'b0110, 0, 32'h100, 32'h203, 0);
    cyc(1, 0, 2'b00, 4'b0000, 0, 0, 0, 0);
    // Redirect during stall is latched; later requests ignored until applied
    cyc(1, 0, 2'b10, 4'b0100, 0, 32'h40, 0, 0);
    repeat (2) cyc(1, 0, 2'b01, 4'b0001, 32'h80, 0, 0, 0);
    cyc(1, 1, 2'b01, 4'b0001, 32'h80, 0, 0, 0);
    cyc(1, 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    // Kind 11 is not a request
    cyc(1, 1, 2'b01, 4'b0011, 32'h300, 0, 32'h300, 0);
    cyc(1, 1, 2'b11, 4'b0000, 32'h300, 32'h300, 32'h300, 32'h300);
    // Mid-group target (aligned instance sees lane0 dead for one group)
    cyc(1, 1, 2'b01, 4'b0001, 32'h104, 0, 0, 0);
    repeat (2) cyc(1, 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    // Address wrap at the top of the space
    cyc(1, 1, 2'b01, 4'b0001, 32'hFFFF_FFFC, 0, 0, 0);
    repeat (2) cyc(1, 1, 2'b00, 4'b0000, 0, 0, 0, 0);
    // Reset while a redirect is pending discards it
    cyc(1, 0, 2'b01, 4'b0001, 32'h500, 0, 0, 0);
    cyc(0, 0, 2'b00, 4'b0000, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 2'b00, 4'b0000, 0, 0, 0, 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) < 7),
          2'($urandom), 4'($urandom),
          $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
